control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have a clk input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have a clr input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have a start input, 1 bit: begin one fetch/execute sequence; sampled only in IDLE.
REQ-004 The block SHALL have a mem_ready input, 1 bit: memory data valid on MDataIn.
REQ-005 The block SHALL have an ir input, 32 bits: current IR contents from the datapath.
REQ-006 The block SHALL have an enable output, 32 bits: one-hot register load enables.
REQ-007 The block SHALL have a bus_select output, 32 bits: one-hot bus source select.
REQ-008 The block SHALL have a mem_read output, 1 bit: MDR loads from MDataIn.
REQ-009 The block SHALL have an inc_pc output, 1 bit: PC increment.
REQ-010 The block SHALL have an alu_op output, 5 bits: operation code to the ALU.
REQ-011 The block SHALL have busy, done and illegal outputs, 1 bit each.
REQ-012 The block SHALL have an instr_count output, 16 bits: completed-instruction count.
REQ-013 Bit indices for enable and bus_select SHALL be: 0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 IR, 24 Z, 25 MAR, 26 OutPort, 27 Y, 28-31 unused (always 0).

Function
REQ-014 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, DONE; every output except instr_count SHALL be a decode of the current state and ir only (Moore).
REQ-015 IDLE: all outputs 0 except instr_count; start=1 -> T0, otherwise stay in IDLE.
REQ-016 T0: bus_select[20]=1, enable[25]=1, inc_pc=1; -> T1.
REQ-017 T1: mem_read=1, enable[21]=1; stay in T1 while mem_ready=0; -> T2 on mem_ready=1.
REQ-018 T2: bus_select[21]=1, enable[23]=1; -> T3.
REQ-019 Decode in T3 onward SHALL use op=ir[31:27], ra=ir[26:23], rb=ir[22:19] and rc=ir[18:15].
REQ-020 Legal ops SHALL be 00011-01110 (three-register ALU: rd=ra, sources rb/rc), 01111 MUL and 10000 DIV (sources ra/rb).
REQ-021 In T3 an illegal op SHALL go directly to DONE with illegal=1 and no register enabled.
REQ-022 T3: Y is loaded from the first source register (rb for ALU ops, ra for MUL/DIV): bus_select[src1]=1, enable[27]=1; -> T4.
REQ-023 T4: bus_select[src2]=1 (rc for ALU ops, rb for MUL/DIV), enable[24]=1, alu_op=op; -> T5.
REQ-024 alu_op SHALL be 0 in every state other than T4.
REQ-025 T5: bus_select[19]=1; enable[17]=1 for MUL/DIV, else enable[rd]=1; MUL/DIV -> T6, else -> DONE.
REQ-026 T6: bus_select[18]=1, enable[16]=1; -> DONE.
REQ-027 DONE: done=1 for exactly one cycle; illegal holds its decoded value; -> IDLE unconditionally.
REQ-028 start asserted outside IDLE SHALL be ignored and not queued.
REQ-029 busy=1 in every state except IDLE.
REQ-030 At most one bus_select bit SHALL be set in any state.
REQ-031 instr_count SHALL increment by 1 on each DONE->IDLE transition, including illegal ops, and wrap from 0xFFFF to 0x0000.

Reset
REQ-032 clr=1 SHALL force IDLE immediately, from any state including T1 while waiting on mem_ready.
REQ-033 While clr=1: enable, bus_select, mem_read, inc_pc, alu_op, busy, done, illegal and instr_count SHALL all be 0.
REQ-034 After clr deasserts, the block SHALL remain in IDLE until start is sampled high on a rising edge.

Verification
REQ-035 MUL fetch/execute: clr pulse, start=1, mem_ready=1, ir=0x7B380000 -> states T0..T6 in 8 cycles; T3 bus_select=bit6, T4 bus_select=bit7 with alu_op=01111; T5 enable=bit17, T6 enable=bit16; done pulse; instr_count=1.
REQ-036 ALU op: ir=0x1A388000 (op 00011, rd=R4, rb=R7, rc=R1) -> T3 bus_select=bit7, T4 bus_select=bit1, T5 enable=bit4, no T6; done 7 cycles after start.
REQ-037 Memory wait: mem_ready held low 5 cycles in T1 -> mem_read and enable[21] stay high for 6 cycles; T2 entered on the cycle after mem_ready rises.
REQ-038 Illegal op: ir=0xF8000000 -> DONE directly after T3, illegal=1, no Y/Z/R enable seen; instr_count increments.
REQ-039 Reset mid-op: clr asserted in T4 -> same-cycle IDLE with all outputs 0; start pulsed during T2 of the next run -> ignored, exactly one done.
REQ-040 Wrap: preload by 65535 completed ops, one more -> instr_count=0x0000.

Source files
------------

// File: rtl/control_sequencer.sv
// Fetch/execute control sequencer: walks IDLE->T0..T6->DONE and decodes
// one-hot register load enables and bus source selects from state and IR.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [31:0] enable,
    output logic [31:0] bus_select,
    output logic        mem_read,
    output logic        inc_pc,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [15:0] instr_count,
    output logic [3:0]  dbg_state_o
);

    localparam int IDX_HI      = 16;
    localparam int IDX_LO      = 17;
    localparam int IDX_ZHIGH   = 18;
    localparam int IDX_ZLOW    = 19;
    localparam int IDX_PC      = 20;
    localparam int IDX_MDR     = 21;
    localparam int IDX_IR      = 23;
    localparam int IDX_Z       = 24;
    localparam int IDX_MAR     = 25;
    localparam int IDX_Y       = 27;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_DONE = 4'd8
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] instr_count_q, instr_count_d;

    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        is_alu, is_muldiv, is_legal;
    logic [4:0]  src1_idx, src2_idx, dst_idx;
    logic        ir_unused;

    assign op = ir[31:27];
    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];
    assign ir_unused = ^ir[14:0];

    assign is_alu    = (op >= 5'd3) && (op <= 5'd14);
    assign is_muldiv = (op == 5'd15) || (op == 5'd16);
    assign is_legal  = is_alu || is_muldiv;

    // MUL/DIV read ra/rb and write HI/LO; ALU ops read rb/rc and write ra.
    assign src1_idx = is_muldiv ? {1'b0, ra} : {1'b0, rb};
    assign src2_idx = is_muldiv ? {1'b0, rb} : {1'b0, rc};
    assign dst_idx  = {1'b0, ra};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= S_IDLE;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = is_legal ? S_T4 : S_DONE;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = is_muldiv ? S_T6 : S_DONE;
            S_T6:   state_d = S_DONE;
            S_DONE: begin
                state_d       = S_IDLE;
                instr_count_d = instr_count_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        enable     = 32'd0;
        bus_select = 32'd0;
        mem_read   = 1'b0;
        inc_pc     = 1'b0;
        alu_op     = 5'd0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_T0: begin
                bus_select[IDX_PC] = 1'b1;
                enable[IDX_MAR]    = 1'b1;
                inc_pc             = 1'b1;
            end
            S_T1: begin
                mem_read        = 1'b1;
                enable[IDX_MDR] = 1'b1;
            end
            S_T2: begin
                bus_select[IDX_MDR] = 1'b1;
                enable[IDX_IR]      = 1'b1;
            end
            S_T3: begin
                if (is_legal) begin
                    bus_select[src1_idx] = 1'b1;
                    enable[IDX_Y]        = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                bus_select[src2_idx] = 1'b1;
                enable[IDX_Z]        = 1'b1;
                alu_op               = op;
            end
            S_T5: begin
                bus_select[IDX_ZLOW] = 1'b1;
                if (is_muldiv) enable[IDX_LO] = 1'b1;
                else           enable[dst_idx] = 1'b1;
            end
            S_T6: begin
                bus_select[IDX_ZHIGH] = 1'b1;
                enable[IDX_HI]        = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = ~is_legal;
            end
            default: ;
        endcase
    end

    assign instr_count = instr_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a planner expands each instruction
// into its expected per-cycle output beats; a monitor pops and compares them.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr, start, mem_ready;
    logic [31:0] ir;
    logic [31:0] enable, bus_select;
    logic        mem_read, inc_pc, busy, done, illegal;
    logic [4:0]  alu_op;
    logic [15:0] instr_count;
    logic [3:0]  dbg_state;

    typedef struct packed {
        logic [31:0] en;
        logic [31:0] bus;
        logic        mr;
        logic        inc;
        logic [4:0]  aop;
        logic        dn;
        logic        ill;
        logic [15:0] cnt;
    } beat_t;

    beat_t       exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] model_cnt = 16'd0;

    control_sequencer dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .mem_ready   (mem_ready),
        .ir          (ir),
        .enable      (enable),
        .bus_select  (bus_select),
        .mem_read    (mem_read),
        .inc_pc      (inc_pc),
        .alu_op      (alu_op),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .instr_count (instr_count),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] one(input int i);
        logic [31:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic void push_beat(input logic [31:0] en, input logic [31:0] bus,
                                      input logic mr, input logic inc, input logic [4:0] aop,
                                      input logic dn, input logic ill);
        beat_t b;
        b.en = en; b.bus = bus; b.mr = mr; b.inc = inc;
        b.aop = aop; b.dn = dn; b.ill = ill; b.cnt = model_cnt;
        exp_q.push_back(b);
    endfunction

    // Expected cycle-by-cycle outputs of one instruction, straight from the state table.
    function automatic void plan_op(input logic [31:0] iv, input int wait_n, input bit abort);
        logic [4:0] op = iv[31:27];
        int  ra = int'(iv[26:23]);
        int  rb = int'(iv[22:19]);
        int  rc = int'(iv[18:15]);
        bit  md = (op == 5'd15) || (op == 5'd16);
        bit  al = (op >= 5'd3) && (op <= 5'd14);
        push_beat(one(25), one(20), 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i <= wait_n; i++)
            push_beat(one(21), '0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        push_beat(one(23), one(21), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        if (!(md || al)) begin
            push_beat('0, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            push_beat('0, '0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
            return;
        end
        push_beat(one(27), one(md ? ra : rb), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        if (abort) return;
        push_beat(one(24), one(md ? rb : rc), 1'b0, 1'b0, op, 1'b0, 1'b0);
        push_beat(one(md ? 17 : ra), one(19), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        if (md) push_beat(one(16), one(18), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        push_beat('0, '0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    endfunction

    initial begin : monitor
        beat_t act, e;
        forever begin
            @(negedge clk);
            if (!clr && busy) begin
                act = '{enable, bus_select, mem_read, inc_pc, alu_op, done, illegal, instr_count};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_busy got state=%0d en=%h bus=%h done=%b", dbg_state, enable, bus_select, done);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        bad++;
                        $display("FAIL beat got en=%h bus=%h mr=%b inc=%b aop=%h dn=%b ill=%b cnt=%h want en=%h bus=%h mr=%b inc=%b aop=%h dn=%b ill=%b cnt=%h",
                                 act.en, act.bus, act.mr, act.inc, act.aop, act.dn, act.ill, act.cnt,
                                 e.en, e.bus, e.mr, e.inc, e.aop, e.dn, e.ill, e.cnt);
                    end
                end
            end
        end
    end

    task automatic chk_idle(input string name);
        total++;
        if ({enable, bus_select, mem_read, inc_pc, alu_op, busy, done, illegal} !== '0 ||
            instr_count !== model_cnt) begin
            bad++;
            $display("FAIL %s got en=%h bus=%h mr=%b inc=%b aop=%h busy=%b dn=%b ill=%b cnt=%h want all zero cnt=%h",
                     name, enable, bus_select, mem_read, inc_pc, alu_op, busy, done, illegal, instr_count, model_cnt);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] iv, input int wait_n,
                          input bit stray, input bit abort);
        int budget;
        plan_op(iv, wait_n, abort);
        @(negedge clk); start = 1'b1; ir = iv; mem_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (wait_n + 1) @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        if (stray) start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (abort) begin
            @(posedge clk); #2; clr = 1'b1; #1;
            model_cnt = 16'd0;
            chk_idle({name, "_clr_same_cycle"});
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL %s_pending got %0d beats left want 0", name, exp_q.size());
                exp_q.delete();
            end
            @(negedge clk); clr = 1'b0;
            repeat (2) @(negedge clk);
            #1 chk_idle({name, "_stay_idle"});
            return;
        end
        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk); #1; budget--;
        end
        if (budget == 0) begin
            total++; bad++;
            $display("FAIL %s_timeout got %0d beats left want 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk); #1;
        model_cnt = model_cnt + 16'd1;
        chk_idle({name, "_idle_after"});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [31:0] rv;
        logic [4:0]  op;
        int          r;
        clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0;
        repeat (2) @(negedge clk);
        #1 chk_idle("reset");
        @(negedge clk); clr = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_idle("idle_no_start");

        run_op("mul",     32'h7B38_0000, 0, 1'b0, 1'b0);
        run_op("alu_add", 32'h1A38_8000, 0, 1'b0, 1'b0);
        run_op("mem_wait",32'h2468_0000, 5, 1'b0, 1'b0);
        run_op("illegal", 32'hF800_0000, 0, 1'b0, 1'b0);
        run_op("div",     32'h8123_4567, 2, 1'b1, 1'b0);
        run_op("abort",   32'h7B38_0000, 1, 1'b0, 1'b1);
        run_op("stray",   32'h6ABC_D000, 0, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      op = 5'($urandom_range(3, 14));
            else if (r < 8) op = 5'($urandom_range(15, 16));
            else if (r < 9) op = 5'($urandom_range(0, 2));
            else            op = 5'($urandom_range(17, 31));
            rv = $urandom();
            rv[31:27] = op;
            run_op("rand", rv, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);
        end

        @(negedge clk);
        force dut.instr_count_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.instr_count_q;
        model_cnt = 16'hFFFE;
        #1 chk_idle("preload");
        run_op("to_ffff", 32'h1A38_8000, 0, 1'b0, 1'b0);
        run_op("wrap",    32'hF800_0000, 1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
